// File: rtl/e203_exu_wbck_sched.sv
// Write-back scheduler for the single integer register-file write port, plus the
// destination scoreboard that lets dispatch stall on RAW/WAW hazards.
module e203_exu_wbck_sched #(
  parameter int STARVE_MAX = 7,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [14:0] req_idx,
  input  logic [95:0] req_dat,
  output logic        wbck_dest_ena,
  output logic [4:0]  wbck_dest_idx,
  output logic [31:0] wbck_dest_dat,
  input  logic        disp_valid,
  input  logic [4:0]  disp_idx,
  output logic        disp_ready,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        sb_empty
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] wait_cnt [3];
  logic [2:0]       starved;
  logic [2:0]       grant;
  logic [31:0]      busy;
  logic [31:0]      busy_nxt;
  logic             disp_fire;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    starved = '0;
    for (int i = 0; i < 3; i++) begin
      starved[i] = req_valid[i] && (wait_cnt[i] == STARVE_LIM);
    end
  end

  // Descending scan so the lowest-index candidate is the one left standing.
  always_comb begin
    grant = '0;
    if (!rst) begin
      for (int i = 2; i >= 0; i--) begin
        if ((|starved) ? starved[i] : req_valid[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wbck_dest_idx = '0;
    wbck_dest_dat = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) begin
        wbck_dest_idx = req_idx[5*i +: 5];
        wbck_dest_dat = req_dat[32*i +: 32];
      end
    end
  end

  assign req_ready     = grant;
  assign wbck_dest_ena = |grant;

  // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || grant[i] || !req_valid[i]) begin
        wait_cnt[i] <= '0;
      end else if (wait_cnt[i] != STARVE_LIM) begin
        wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  // A write retiring the same register releases the WAW stall in that cycle.
  assign disp_ready = !rst && ((disp_idx == 5'd0) || !busy[disp_idx] ||
                               (wbck_dest_ena && (wbck_dest_idx == disp_idx)));
  assign disp_fire  = disp_valid && disp_ready && (disp_idx != 5'd0);

  // Clear is applied before set, so a same-cycle set of the same index wins.
  always_comb begin
    busy_nxt = busy;
    if (wbck_dest_ena) busy_nxt[wbck_dest_idx] = 1'b0;
    if (disp_fire)     busy_nxt[disp_idx]      = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: the busy vector is plain flops, not a memory, so it is reset with everything else.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1_idx];
  assign rs2_busy = busy[rs2_idx];
  assign sb_empty = (busy == '0);

endmodule

// File: tb/tb_e203_exu_wbck_sched.sv
// Bench for e203_exu_wbck_sched: directed scenarios followed by random traffic,
// all checked cycle-by-cycle against a behavioural model of arbitration and scoreboard.
module tb_e203_exu_wbck_sched;

  localparam int SM = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_idx;
  logic [95:0] req_dat;
  logic        wbck_dest_ena;
  logic [4:0]  wbck_dest_idx;
  logic [31:0] wbck_dest_dat;
  logic        disp_valid;
  logic [4:0]  disp_idx;
  logic        disp_ready;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        sb_empty;

  always #5 clk = ~clk;

  e203_exu_wbck_sched #(.STARVE_MAX(SM), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_dat(req_dat),
    .wbck_dest_ena(wbck_dest_ena), .wbck_dest_idx(wbck_dest_idx), .wbck_dest_dat(wbck_dest_dat),
    .disp_valid(disp_valid), .disp_idx(disp_idx), .disp_ready(disp_ready),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .sb_empty(sb_empty)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: per-channel count of consecutive ungranted valid cycles
  // and a plain array of pending destination registers.
  int          cnt_m [3];
  int          age   [3];
  bit          busy_m [32];
  int          g_c;
  logic [4:0]  widx_c;
  logic [31:0] wdat_c;
  logic        dr_c;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_empty();
    for (int r = 0; r < 32; r++) if (busy_m[r]) return 1'b0;
    return 1'b1;
  endfunction

  // Settle combinational outputs and compare every output against the model.
  task automatic eval();
    #1;
    g_c = -1;
    if (!rst) begin
      for (int i = 0; i < 3; i++) if (g_c < 0 && req_valid[i] && cnt_m[i] == SM) g_c = i;
      for (int i = 0; i < 3; i++) if (g_c < 0 && req_valid[i]) g_c = i;
    end
    widx_c = (g_c < 0) ? 5'd0  : req_idx[5*g_c +: 5];
    wdat_c = (g_c < 0) ? 32'd0 : req_dat[32*g_c +: 32];
    dr_c   = !rst && (disp_idx == 5'd0 || !busy_m[disp_idx] || (g_c >= 0 && widx_c == disp_idx));
    check("req_ready",  96'(req_ready),     (g_c < 0) ? 96'd0 : 96'(1 << g_c));
    check("wbck_ena",   96'(wbck_dest_ena), 96'(g_c >= 0));
    check("wbck_idx",   96'(wbck_dest_idx), 96'(widx_c));
    check("wbck_dat",   96'(wbck_dest_dat), 96'(wdat_c));
    check("disp_ready", 96'(disp_ready),    96'(dr_c));
    check("rs1_busy",   96'(rs1_busy),      96'(busy_m[rs1_idx]));
    check("rs2_busy",   96'(rs2_busy),      96'(busy_m[rs2_idx]));
    check("sb_empty",   96'(sb_empty),      96'(model_empty()));
    if (g_c >= 0) check("starve_bound", 96'(age[g_c] <= SM + 1), 96'd1);
  endtask

  // Clock edge, then advance the model using the inputs of the cycle just ended.
  task automatic adv();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst || g_c == i || !req_valid[i]) begin
        cnt_m[i] = 0;
        age[i]   = 0;
      end else begin
        cnt_m[i] = (cnt_m[i] < SM) ? cnt_m[i] + 1 : SM;
        age[i]   = age[i] + 1;
      end
    end
    if (rst) begin
      for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
    end else begin
      if (g_c >= 0) busy_m[widx_c] = 1'b0;
      if (disp_valid && dr_c && disp_idx != 5'd0) busy_m[disp_idx] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic tick();
    eval();
    adv();
  endtask

  task automatic set_req(input int c, input logic [4:0] idx, input logic [31:0] dat);
    req_valid[c]        = 1'b1;
    req_idx[5*c +: 5]   = idx;
    req_dat[32*c +: 32] = dat;
  endtask

  task automatic idle();
    req_valid  = '0;
    disp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_idx = '0; req_dat = '0;
    disp_valid = 1'b0; disp_idx = '0; rs1_idx = '0; rs2_idx = '0;
    for (int i = 0; i < 3; i++) begin cnt_m[i] = 0; age[i] = 0; end
    for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
    @(negedge clk);

    // Reset held for two cycles, then reset-state outputs.
    tick();
    eval();
    check("rst_disp_ready_low", 96'(disp_ready), 96'd0);
    adv();
    rst = 1'b0;
    eval();
    check("reset_req_ready",  96'(req_ready),     96'd0);
    check("reset_ena",        96'(wbck_dest_ena), 96'd0);
    check("reset_disp_ready", 96'(disp_ready),    96'd1);
    check("reset_sb_empty",   96'(sb_empty),      96'd1);
    adv();
    set_req(1, 5'd1, 32'h11); set_req(2, 5'd2, 32'h22);
    eval();
    check("valid110_ready", 96'(req_ready), 96'b010);
    adv();
    idle(); tick();

    // Fixed priority with all three requesting.
    set_req(0, 5'd5, 32'hAAAA_AAAA); set_req(1, 5'd6, 32'hBBBB_BBBB); set_req(2, 5'd7, 32'hCCCC_CCCC);
    eval();
    check("prio_ready", 96'(req_ready),     96'b001);
    check("prio_idx",   96'(wbck_dest_idx), 96'd5);
    check("prio_dat",   96'(wbck_dest_dat), 96'hAAAA_AAAA);
    adv();
    idle(); tick();

    // Starvation: ch2 wins on its 8th valid cycle against continuous ch0.
    set_req(0, 5'd5, 32'h0000_0A0A); set_req(2, 5'd7, 32'h0000_0C0C);
    for (int k = 1; k <= 9; k++) begin
      eval();
      check($sformatf("starve_cycle%0d", k), 96'(req_ready), (k == 8) ? 96'b100 : 96'b001);
      adv();
    end
    idle(); tick();

    // RAW: dispatch x10, LSU writes it back four cycles later.
    disp_valid = 1'b1; disp_idx = 5'd10;
    eval(); check("raw_disp_ready", 96'(disp_ready), 96'd1); adv();
    disp_valid = 1'b0; rs1_idx = 5'd10;
    eval(); check("raw_busy_c1", 96'(rs1_busy), 96'd1); adv();
    tick(); tick();
    set_req(1, 5'd10, 32'h1234_5678);
    eval();
    check("raw_lsu_grant", 96'(req_ready), 96'b010);
    check("raw_no_bypass", 96'(rs1_busy),  96'd1);
    adv();
    idle();
    eval(); check("raw_busy_c5", 96'(rs1_busy), 96'd0); adv();

    // WAW stall and same-cycle release.
    disp_valid = 1'b1; disp_idx = 5'd3; tick();
    eval(); check("waw_stall", 96'(disp_ready), 96'd0); adv();
    set_req(1, 5'd3, 32'h3333);
    eval();
    check("waw_release", 96'(disp_ready), 96'd1);
    check("waw_grant",   96'(req_ready),  96'b010);
    adv();
    idle(); rs2_idx = 5'd3;
    eval(); check("waw_set_wins", 96'(rs2_busy), 96'd1); adv();
    set_req(0, 5'd3, 32'h3030); tick();
    idle(); tick();

    // x0 is never tracked but its writes still use the port.
    disp_valid = 1'b1; disp_idx = 5'd0;
    eval();
    check("x0_disp_ready", 96'(disp_ready), 96'd1);
    check("x0_sb_empty",   96'(sb_empty),   96'd1);
    adv();
    disp_valid = 1'b0; set_req(0, 5'd0, 32'hDEAD_BEEF);
    eval();
    check("x0_wr_ena", 96'(wbck_dest_ena), 96'd1);
    check("x0_wr_idx", 96'(wbck_dest_idx), 96'd0);
    adv();
    idle();
    eval(); check("x0_sb_still_empty", 96'(sb_empty), 96'd1); adv();

    // Synchronous reset in the middle of traffic.
    disp_valid = 1'b1; disp_idx = 5'd9; tick();
    rst = 1'b1; disp_idx = 5'd12;
    set_req(0, 5'd4, 32'h4); set_req(1, 5'd5, 32'h5); set_req(2, 5'd6, 32'h6);
    eval();
    check("midrst_ready",      96'(req_ready),     96'd0);
    check("midrst_ena",        96'(wbck_dest_ena), 96'd0);
    check("midrst_disp_ready", 96'(disp_ready),    96'd0);
    adv();
    rst = 1'b0; idle(); rs1_idx = 5'd9;
    eval();
    check("midrst_sb_empty", 96'(sb_empty), 96'd1);
    check("midrst_rs1",      96'(rs1_busy), 96'd0);
    adv();

    // Random traffic; requesters hold their request until granted.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(199) == 0);
      for (int c = 0; c < 3; c++) begin
        if (!req_valid[c] && $urandom_range(1) == 1)
          set_req(c, 5'($urandom_range(7)), $urandom);
      end
      disp_valid = 1'($urandom_range(1));
      disp_idx   = 5'($urandom_range(7));
      rs1_idx    = 5'($urandom_range(7));
      rs2_idx    = 5'($urandom_range(7));
      tick();
      if (g_c >= 0) req_valid[g_c] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
